led_pwm_scheduler: RTL and testbench
====================================

# led_pwm_scheduler

Four-channel LED brightness controller. It shares one 1 µs tick generator and one PWM period counter across four LED channels, and gives each channel its own programmable mode: off, static duty, breath ramp or blink. Mode changes come in over a valid/ready command port. They are applied only at PWM period boundaries, so no output ever sees a truncated or glitched period. The block sits between the board-level control logic and the LED pins and replaces per-LED free-running breath generators.

## Interface
- CLK_frequency, 100_000_000: input clock frequency in Hz. Tick divider CLK_DIV = CLK_frequency/1_000_000, which must be ≥ 1.
- BRIGHT_division, 1000: PWM steps per period (1 µs per step). Range 2..2047.
- clk_i  in  1  system clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command can be accepted.
- cmd_ch_i  in  2  target channel, 0..3.
- cmd_mode_i  in  2  mode: 0 OFF, 1 STATIC, 2 BREATH, 3 BLINK.
- cmd_level_i  in  11  level. STATIC/BREATH: duty or peak duty. BLINK: half-period in PWM periods.
- led_o  out  4  registered PWM outputs, one bit per channel.
- pwm_sync_o  out  1  one-cycle pulse on the last clock of each PWM period.

## Operation
- Reset state:
  - All channels OFF, level 0, duty 0, direction up, blink counter 0, blink phase on.
  - led_o = 0, cmd_ready_o = 1, pwm_sync_o = 0.
  - Tick and PWM counters = 0.
- Tick: cnt_1u counts 0..CLK_DIV-1. tick = (cnt_1u == CLK_DIV-1).
- Period counter: cnt_pwm advances on tick through 0..BRIGHT_division-1, then wraps.
- Boundary: bnd = tick & (cnt_pwm == BRIGHT_division-1). pwm_sync_o = bnd.
- Command handshake:
  - A command is accepted when cmd_valid_i & cmd_ready_o. It is stored in a single pending register, and cmd_ready_o drops on the next cycle.
  - The pending command is applied on the next bnd edge strictly after acceptance. A command accepted in a bnd cycle waits for the following boundary.
  - cmd_ready_o returns to 1 on the cycle after the apply edge.
  - Inputs are ignored while cmd_ready_o = 0.
- Apply:
  - The target channel's mode and level are overwritten with the pending values.
  - Its dynamic state is reset to duty 0, direction up, blink counter 0, blink phase on.
  - For that channel, the apply replaces the normal per-boundary update on that edge.
  - STATIC takes effect at once: duty = min(level, BRIGHT_division) on the apply edge.
- Per-boundary update of each channel not being applied:
  - OFF: duty = 0.
  - STATIC: duty = min(level, BRIGHT_division).
  - BREATH:
    - peak = min(level, BRIGHT_division).
    - Going up: duty+1. When duty == peak, the direction flips to down and duty is held for that boundary.
    - Going down: duty-1. When duty == 0, the direction flips to up and duty is held.
    - If peak == 0, duty stays 0.
  - BLINK:
    - The blink counter increments. When it reaches level-1, it clears and the phase toggles.
    - Phase on gives duty = BRIGHT_division; phase off gives duty = 0.
    - level 0 forces duty 0 with phase on.
- Output: led_o[ch] <= (cnt_pwm < duty[ch]) every cycle. duty = 0 gives constant low; duty = BRIGHT_division gives constant high.
- Arithmetic: all counters and duty are 11 bits unsigned. Clamping prevents overflow, and duty never leaves 0..BRIGHT_division.

## Timing
- led_o lags cnt_pwm by one register stage.
- The first period produced with a new duty starts on the cycle after the apply edge, when cnt_pwm = 0. The corresponding led_o appears one cycle later.
- Command latency from acceptance to apply: 1 to BRIGHT_division·CLK_DIV clocks, depending on where the period counter is.
- BREATH full cycle (0 → peak → 0): 2·peak + 2 PWM periods.
- BLINK: level periods on, then level periods off.
- Asynchronous reset mid-operation returns everything to the reset state immediately, including dropping any pending command. Counting resumes from 0 on the first clock after release.

## Test plan
All scenarios use CLK_frequency = 4_000_000 and BRIGHT_division = 8 (period = 32 clocks).
- Reset, then idle → led_o = 0, cmd_ready_o = 1, and pwm_sync_o pulses every 32 clocks.
- STATIC ch0, level 3 → after the next boundary, led_o[0] is high for 12 clocks of every 32; other channels stay 0.
- STATIC ch1, level 20 → clamps to 8, so led_o[1] is constantly high from the first full period.
- BREATH ch2, level 2 → high-clock counts per period are 0, 4, 8, 8, 4, 0, 0, 4, … (period 6).
- BLINK ch3, level 2 → high for 64 clocks, low for 64 clocks, repeating.
- Handshake:
  - Issue a command mid-period → cmd_ready_o = 0 until the cycle after the boundary.
  - A second valid held during that window is accepted only once ready returns.
  - Assert rst_n low while a command is pending → the command is discarded, with led_o = 0 and cmd_ready_o = 1 during reset.

Source files
------------

// File: rtl/led_pwm_scheduler_if.sv
// Command port of the four-channel LED PWM scheduler: one mode/level update per handshake.
interface led_pwm_scheduler_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_ch_i;
    logic [1:0]  cmd_mode_i;
    logic [10:0] cmd_level_i;

    modport master (
        output cmd_valid_i, cmd_ch_i, cmd_mode_i, cmd_level_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i, cmd_ch_i, cmd_mode_i, cmd_level_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/led_pwm_scheduler.sv
// Four LED channels sharing one 1 us tick and one PWM period counter; each channel runs
// OFF/STATIC/BREATH/BLINK, and mode commands only take effect on a period boundary.
module led_pwm_scheduler #(
    parameter int unsigned CLK_frequency   = 100_000_000,
    parameter int unsigned BRIGHT_division = 1000
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    led_pwm_scheduler_if.slave        cmd,
    output logic [3:0]                led_o,
    output logic                      pwm_sync_o
);
    localparam int unsigned CLK_DIV  = CLK_frequency / 1_000_000;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] BD       = 11'(BRIGHT_division);
    localparam logic [10:0] PWM_LAST = 11'(BRIGHT_division - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_BREATH = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        HS_IDLE,
        HS_PEND
    } hs_e;

    function automatic logic [10:0] clamp_bd(input logic [10:0] l);
        return (l > BD) ? BD : l;
    endfunction

    logic [DIV_W-1:0] cnt_1u;
    logic [10:0]      cnt_pwm;
    logic             tick;
    logic             bnd;

    assign tick       = (cnt_1u == DIV_LAST);
    assign bnd        = tick & (cnt_pwm == PWM_LAST);
    assign pwm_sync_o = bnd;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_1u  <= '0;
            cnt_pwm <= '0;
        end else begin
            cnt_1u <= tick ? '0 : cnt_1u + DIV_W'(1);
            if (bnd)
                cnt_pwm <= '0;
            else if (tick)
                cnt_pwm <= cnt_pwm + 11'd1;
        end
    end

    // Command handshake: a single pending slot, released by the boundary that applies it.
    hs_e         hs_q, hs_d;
    logic [1:0]  pend_ch;
    mode_e       pend_mode;
    logic [10:0] pend_level;
    logic        accept;
    logic        apply;

    assign accept = cmd.cmd_valid_i & (hs_q == HS_IDLE);
    assign apply  = (hs_q == HS_PEND) & bnd;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            hs_q <= HS_IDLE;
        else
            hs_q <= hs_d;
    end

    always_comb begin
        hs_d            = hs_q;
        cmd.cmd_ready_o = 1'b0;
        case (hs_q)
            HS_IDLE: begin
                cmd.cmd_ready_o = 1'b1;
                if (cmd.cmd_valid_i)
                    hs_d = HS_PEND;
            end
            HS_PEND: begin
                if (bnd)
                    hs_d = HS_IDLE;
            end
            default: hs_d = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pend_ch    <= '0;
            pend_mode  <= MODE_OFF;
            pend_level <= '0;
        end else if (accept) begin
            pend_ch    <= cmd.cmd_ch_i;
            pend_mode  <= mode_e'(cmd.cmd_mode_i);
            pend_level <= cmd.cmd_level_i;
        end
    end

    // Per-channel state
    mode_e       mode_q  [4];
    mode_e       mode_d  [4];
    logic [10:0] level_q [4];
    logic [10:0] level_d [4];
    logic [10:0] duty_q  [4];
    logic [10:0] duty_d  [4];
    logic [10:0] bcnt_q  [4];
    logic [10:0] bcnt_d  [4];
    logic [3:0]  down_q, down_d;
    logic [3:0]  bon_q, bon_d;

    always_comb begin
        mode_d  = mode_q;
        level_d = level_q;
        duty_d  = duty_q;
        bcnt_d  = bcnt_q;
        down_d  = down_q;
        bon_d   = bon_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (apply && (pend_ch == 2'(i))) begin
                mode_d[i]  = pend_mode;
                level_d[i] = pend_level;
                duty_d[i]  = (pend_mode == MODE_STATIC) ? clamp_bd(pend_level) : '0;
                bcnt_d[i]  = '0;
                down_d[i]  = 1'b0;
                bon_d[i]   = 1'b1;
            end else if (bnd) begin
                case (mode_q[i])
                    MODE_OFF:    duty_d[i] = '0;
                    MODE_STATIC: duty_d[i] = clamp_bd(level_q[i]);
                    MODE_BREATH: begin
                        if (clamp_bd(level_q[i]) == '0) begin
                            duty_d[i] = '0;
                        end else if (!down_q[i]) begin
                            if (duty_q[i] >= clamp_bd(level_q[i]))
                                down_d[i] = 1'b1;
                            else
                                duty_d[i] = duty_q[i] + 11'd1;
                        end else begin
                            if (duty_q[i] == '0)
                                down_d[i] = 1'b0;
                            else
                                duty_d[i] = duty_q[i] - 11'd1;
                        end
                    end
                    MODE_BLINK: begin
                        // Duty follows the phase in force at this boundary, so each phase
                        // lasts exactly `level` periods after the apply period.
                        if (level_q[i] == '0) begin
                            duty_d[i] = '0;
                            bcnt_d[i] = '0;
                            bon_d[i]  = 1'b1;
                        end else begin
                            duty_d[i] = bon_q[i] ? BD : '0;
                            if (bcnt_q[i] == level_q[i] - 11'd1) begin
                                bcnt_d[i] = '0;
                                bon_d[i]  = ~bon_q[i];
                            end else begin
                                bcnt_d[i] = bcnt_q[i] + 11'd1;
                            end
                        end
                    end
                    default: duty_d[i] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                mode_q[i]  <= MODE_OFF;
                level_q[i] <= '0;
                duty_q[i]  <= '0;
                bcnt_q[i]  <= '0;
            end
            down_q <= '0;
            bon_q  <= '1;
            led_o  <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                mode_q[i]  <= mode_d[i];
                level_q[i] <= level_d[i];
                duty_q[i]  <= duty_d[i];
                bcnt_q[i]  <= bcnt_d[i];
                led_o[i]   <= (cnt_pwm < duty_q[i]);
            end
            down_q <= down_d;
            bon_q  <= bon_d;
        end
    end
endmodule

// File: tb/tb_led_pwm_scheduler.sv
// Directed bench for led_pwm_scheduler at 4 MHz / 8 steps (32 clocks per PWM period).
module tb_led_pwm_scheduler;
    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] led_o;
    logic       pwm_sync_o;

    led_pwm_scheduler_if cmd_if ();

    led_pwm_scheduler #(
        .CLK_frequency  (4_000_000),
        .BRIGHT_division(8)
    ) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .cmd       (cmd_if.slave),
        .led_o     (led_o),
        .pwm_sync_o(pwm_sync_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int hc [4];
    int sc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Leaves the bench in the sync cycle; counts ready-high cycles seen while waiting.
    task automatic wait_sync(input string tag, output int rdy_hi);
        int n = 0;
        rdy_hi = 0;
        while (pwm_sync_o !== 1'b1 && n < 100) begin
            if (cmd_if.cmd_ready_o === 1'b1) rdy_hi++;
            step();
            n++;
        end
        check({tag, "_sync_seen"}, 32'(pwm_sync_o), 1);
    endtask

    task automatic send(input logic [1:0] ch, input logic [1:0] mode,
                        input logic [10:0] level, input bit hold);
        check("ready_idle", 32'(cmd_if.cmd_ready_o), 1);
        cmd_if.cmd_ch_i    = ch;
        cmd_if.cmd_mode_i  = mode;
        cmd_if.cmd_level_i = level;
        cmd_if.cmd_valid_i = 1'b1;
        step();
        check("ready_drop", 32'(cmd_if.cmd_ready_o), 0);
        if (!hold) cmd_if.cmd_valid_i = 1'b0;
    endtask

    task automatic measure(input bit drop_valid);
        for (int ch = 0; ch < 4; ch++) hc[ch] = 0;
        sc = 0;
        for (int c = 0; c < 32; c++) begin
            step();
            for (int ch = 0; ch < 4; ch++) hc[ch] += int'(led_o[ch]);
            sc += int'(pwm_sync_o);
            if (c == 0 && drop_valid) begin
                check("held_cmd_accepted", 32'(cmd_if.cmd_ready_o), 0);
                cmd_if.cmd_valid_i = 1'b0;
            end
        end
        check("sync_per_period", 32'(sc), 1);
    endtask

    task automatic first_sync(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (pwm_sync_o !== 1'b1 && n < 100);
        check(tag, 32'(n), 31);
    endtask

    initial begin
        int rh;
        int breath_exp [8] = '{0, 4, 8, 8, 4, 0, 0, 4};
        int blink_exp  [7] = '{0, 32, 32, 0, 0, 32, 32};

        cmd_if.cmd_valid_i = 1'b0;
        cmd_if.cmd_ch_i    = '0;
        cmd_if.cmd_mode_i  = '0;
        cmd_if.cmd_level_i = '0;

        // Reset and idle
        step();
        step();
        check("rst_led", 32'(led_o), 0);
        check("rst_ready", 32'(cmd_if.cmd_ready_o), 1);
        check("rst_sync", 32'(pwm_sync_o), 0);
        rst_n = 1'b1;
        first_sync("first_sync_latency");
        measure(0);
        check("idle_led", 32'(hc[0] + hc[1] + hc[2] + hc[3]), 0);

        // STATIC ch0 level 3, issued mid-period
        repeat (10) step();
        send(2'd0, 2'd1, 11'd3, 0);
        wait_sync("static0", rh);
        check("static0_ready_pending", 32'(rh), 0);
        check("static0_ready_at_bnd", 32'(cmd_if.cmd_ready_o), 0);
        step();
        check("static0_ready_back", 32'(cmd_if.cmd_ready_o), 1);
        for (int p = 0; p < 2; p++) begin
            measure(0);
            check("static0_ch0_high", 32'(hc[0]), 12);
            check("static0_others", 32'(hc[1] + hc[2] + hc[3]), 0);
        end

        // STATIC ch1 level 20 with a second command (BREATH ch2 level 2) held on valid
        repeat (5) step();
        send(2'd1, 2'd1, 11'd20, 1);
        cmd_if.cmd_ch_i    = 2'd2;
        cmd_if.cmd_mode_i  = 2'd2;
        cmd_if.cmd_level_i = 11'd2;
        wait_sync("static1", rh);
        check("held_ready_pending", 32'(rh), 0);
        check("held_ready_at_bnd", 32'(cmd_if.cmd_ready_o), 0);
        step();
        check("held_ready_back", 32'(cmd_if.cmd_ready_o), 1);
        measure(1);
        check("static1_ch0", 32'(hc[0]), 12);
        check("static1_ch1_clamped", 32'(hc[1]), 32);
        check("static1_ch2_not_yet", 32'(hc[2]), 0);
        for (int p = 0; p < 8; p++) begin
            measure(0);
            check($sformatf("breath_p%0d", p), 32'(hc[2]), 32'(breath_exp[p]));
            check("breath_ch1", 32'(hc[1]), 32);
        end

        // BLINK ch3 level 2
        repeat (7) step();
        send(2'd3, 2'd3, 11'd2, 0);
        wait_sync("blink", rh);
        step();
        for (int p = 0; p < 7; p++) begin
            measure(0);
            check($sformatf("blink_p%0d", p), 32'(hc[3]), 32'(blink_exp[p]));
            check("blink_ch0", 32'(hc[0]), 12);
        end

        // Reset while a command is pending discards it
        repeat (9) step();
        send(2'd0, 2'd1, 11'd8, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_led", 32'(led_o), 0);
        check("midrst_ready", 32'(cmd_if.cmd_ready_o), 1);
        check("midrst_sync", 32'(pwm_sync_o), 0);
        step();
        check("midrst_led_held", 32'(led_o), 0);
        check("midrst_ready_held", 32'(cmd_if.cmd_ready_o), 1);
        rst_n = 1'b1;
        first_sync("midrst_first_sync");
        for (int p = 0; p < 2; p++) begin
            measure(0);
            check("midrst_ch0_discarded", 32'(hc[0]), 0);
            check("midrst_all_off", 32'(hc[1] + hc[2] + hc[3]), 0);
        end
        check("midrst_ready_after", 32'(cmd_if.cmd_ready_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
